// File: rtl/csconvert_mono_tile_if.sv
// ---------------------------------------------------------------------------
// csconvert_mono_tile_if
//
// Purpose:
//   Bundles the pixel-source side and the Y tile memory write side of the
//   mono colour-space / tiling stage into one interface. Widths follow the
//   same parameters as the stage itself, so an instance must be created with
//   the same DATA_WIDTH / TILE_LOG2 / PAGES_LOG2 as the module it connects to.
//
// Signals:
//   en             block enable (low aborts any tile and holds idle)
//   din            raw pixel, scanline order
//   pre_first_in   one-cycle strobe; first pixel of a tile follows next cycle
//   y_out          converted pixel, valid while ywe
//   yaddr          tile memory write address {page, pixel index}
//   ywe            write enable for y_out / yaddr
//   pre_first_out  pre_first_in delayed one cycle
//   tile_done      pulse coincident with the last write of a tile
//   page           page currently being filled
//   overrun        pulse when a tile is restarted before completion
//
// Modports:
//   master  pixel source / testbench side (drives en, din, pre_first_in)
//   slave   the conversion stage (drives all write-side outputs)
// ---------------------------------------------------------------------------
interface csconvert_mono_tile_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_LOG2  = 4,
  parameter int PAGES_LOG2 = 1
);

  localparam int ADDR_WIDTH = PAGES_LOG2 + 2 * TILE_LOG2;

  logic                  en;
  logic [DATA_WIDTH-1:0] din;
  logic                  pre_first_in;

  logic [DATA_WIDTH-1:0] y_out;
  logic [ADDR_WIDTH-1:0] yaddr;
  logic                  ywe;
  logic                  pre_first_out;
  logic                  tile_done;
  logic [PAGES_LOG2-1:0] page;
  logic                  overrun;

  modport master (
    output en,
    output din,
    output pre_first_in,
    input  y_out,
    input  yaddr,
    input  ywe,
    input  pre_first_out,
    input  tile_done,
    input  page,
    input  overrun
  );

  modport slave (
    input  en,
    input  din,
    input  pre_first_in,
    output y_out,
    output yaddr,
    output ywe,
    output pre_first_out,
    output tile_done,
    output page,
    output overrun
  );

endinterface

// File: rtl/csconvert_mono_tile.sv
// ---------------------------------------------------------------------------
// csconvert_mono_tile
//
// Purpose:
//   Monochrome colour-space stage feeding the DCT. Raw pixels arrive in
//   scanline order after a pre_first_in strobe; each one is converted
//   (optionally offset-binary to two's complement) and written into a
//   page-buffered Y tile memory at {page, pixel index}. One square tile of
//   2^TILE_LOG2 x 2^TILE_LOG2 pixels is written per strobe. Completed tiles
//   advance the page so the DCT can read one page while the next is filled.
//   A strobe arriving mid-tile restarts the tile on the same page and flags
//   an overrun. All outputs are registered: a pixel captured in cycle T is
//   written in cycle T+1.
//
// Parameters:
//   DATA_WIDTH  pixel width in bits (>= 2)
//   TILE_LOG2   log2 of tile side
//   PAGES_LOG2  log2 of number of buffer pages
//   SIGNED_OUT  nonzero: invert MSB of each pixel; zero: pass through
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (all state and outputs to 0)
//   bus   csconvert_mono_tile_if.slave: en, din, pre_first_in in;
//         y_out, yaddr, ywe, pre_first_out, tile_done, page, overrun out
// ---------------------------------------------------------------------------
module csconvert_mono_tile #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_LOG2  = 4,
  parameter int PAGES_LOG2 = 1,
  parameter int SIGNED_OUT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  csconvert_mono_tile_if.slave bus
);

  localparam int CNT_WIDTH  = 2 * TILE_LOG2;
  localparam int ADDR_WIDTH = PAGES_LOG2 + CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_INDEX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;

  // fill_page is the page that captures are addressed to. It advances on the
  // capture of the last pixel, so a back-to-back tile's first pixel already
  // lands on the next page. The visible page output is this value delayed
  // by one cycle, which keeps it aligned with the registered write stream.
  logic [PAGES_LOG2-1:0] fill_page;

  logic [DATA_WIDTH-1:0] y_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ywe_q;
  logic                  pfo_q;
  logic                  done_q;
  logic                  ovr_q;
  logic [PAGES_LOG2-1:0] page_q;

  function automatic logic [DATA_WIDTH-1:0] conv(input logic [DATA_WIDTH-1:0] x);
    if (SIGNED_OUT != 0) begin
      return {~x[DATA_WIDTH-1], x[DATA_WIDTH-2:0]};
    end
    return x;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fill_page <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      ywe_q     <= 1'b0;
      pfo_q     <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      page_q    <= '0;
    end else begin
      ywe_q  <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      pfo_q  <= bus.en && bus.pre_first_in;
      page_q <= fill_page;

      if (!bus.en) begin
        // Abort: drop whatever tile was in progress but keep the page, so a
        // partial tile is simply overwritten by the next one.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.pre_first_in) begin
              state <= RUN;
              cnt   <= '0;
            end
          end

          RUN: begin
            y_q    <= conv(bus.din);
            addr_q <= {fill_page, cnt};
            ywe_q  <= 1'b1;

            if (cnt == LAST_INDEX) begin
              done_q    <= 1'b1;
              fill_page <= fill_page + 1'b1;
              cnt       <= '0;
              // A strobe on the last pixel chains straight into the next tile.
              if (!bus.pre_first_in) begin
                state <= IDLE;
              end
            end else if (bus.pre_first_in) begin
              ovr_q <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.y_out         = y_q;
  assign bus.yaddr         = addr_q;
  assign bus.ywe           = ywe_q;
  assign bus.pre_first_out = pfo_q;
  assign bus.tile_done     = done_q;
  assign bus.page          = page_q;
  assign bus.overrun       = ovr_q;

endmodule
